// File: rtl/dispatch_ctrl.sv
// dispatch_ctrl: fetch FIFO, opcode decode + immediate generation, valid/ready issue to INT/MEM/MUL stations.
// Optional performance counters are enabled by defining DISPATCH_PERF_CNT_EN.
`timescale 1ns/1ps
module dispatch_ctrl #(
  parameter int QDEPTH = 4,
  parameter int XLEN   = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            fetch_valid_i,
  input  logic [XLEN-1:0] fetch_instr_i,
  input  logic [XLEN-1:0] fetch_pc_i,
  output logic            fetch_ready_o,
  output logic            disp_valid_o,
  output logic [1:0]      disp_target_o,
  output logic [XLEN-1:0] disp_instr_o,
  output logic [XLEN-1:0] disp_pc_o,
  output logic [XLEN-1:0] disp_imm_o,
  input  logic            rs_int_ready_i,
  input  logic            rs_mem_ready_i,
  input  logic            rs_mul_ready_i,
  output logic            illegal_o,
  output logic [1:0]      state_o
`ifdef DISPATCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_disp_cnt_o,
  output logic [31:0]     perf_stall_cnt_o
`endif
);

  localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = AW + 1;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_STALL = 2'b10;
  localparam logic [1:0] ST_FLUSH = 2'b11;

  localparam logic [1:0] TGT_INT = 2'b00;
  localparam logic [1:0] TGT_MEM = 2'b01;
  localparam logic [1:0] TGT_MUL = 2'b10;

  localparam logic [2:0] IT_I = 3'b000;
  localparam logic [2:0] IT_S = 3'b010;
  localparam logic [2:0] IT_B = 3'b011;
  localparam logic [2:0] IT_J = 3'b100;
  localparam logic [2:0] IT_U = 3'b101;
  localparam logic [2:0] IT_R = 3'b111;

  // Result layout: {legal, target[1:0], ins_type[2:0]}
  function automatic logic [5:0] decode(input logic [6:0] opcode, input logic [6:0] funct7);
    logic [5:0] d;
    case (opcode)
      7'b0000011: d = {1'b1, TGT_MEM, IT_I};
      7'b0100011: d = {1'b1, TGT_MEM, IT_S};
      7'b0010011: d = {1'b1, TGT_INT, IT_I};
      7'b1100111: d = {1'b1, TGT_INT, IT_I};
      7'b1100011: d = {1'b1, TGT_INT, IT_B};
      7'b1101111: d = {1'b1, TGT_INT, IT_J};
      7'b0110111: d = {1'b1, TGT_INT, IT_U};
      7'b0010111: d = {1'b1, TGT_INT, IT_U};
      7'b0110011: d = {1'b1, (funct7 == 7'b0000001) ? TGT_MUL : TGT_INT, IT_R};
      default:    d = {1'b0, TGT_INT, IT_R};
    endcase
    return d;
  endfunction

  // datain is instr[31:7], so instr[k] maps to datain[k-7]
  function automatic logic [XLEN-1:0] imm_gen(input logic [24:0] datain, input logic [2:0] ins_type);
    logic [XLEN-1:0] imm;
    case (ins_type)
      IT_I:    imm = {{20{datain[24]}}, datain[24:13]};
      IT_S:    imm = {{20{datain[24]}}, datain[24:18], datain[4:0]};
      IT_B:    imm = {{19{datain[24]}}, datain[24], datain[0], datain[23:18], datain[4:1], 1'b0};
      IT_J:    imm = {{11{datain[24]}}, datain[24], datain[12:5], datain[13], datain[23:14], 1'b0};
      IT_U:    imm = {datain[24:5], 12'h000};
      default: imm = {XLEN{1'b0}};
    endcase
    return imm;
  endfunction

  logic [XLEN-1:0] instr_mem_r [QDEPTH];
  logic [XLEN-1:0] pc_mem_r    [QDEPTH];
  logic [AW-1:0]   wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]   count_r, count_next_s;
  logic [1:0]      state_r, state_next_s;

  logic            stage_valid_r, stage_valid_next_s;
  logic [1:0]      stage_target_r;
  logic [XLEN-1:0] stage_instr_r, stage_pc_r, stage_imm_r;

  logic [XLEN-1:0] head_instr_s, head_pc_s;
  logic [5:0]      head_dec_s;
  logic            fifo_empty_s, fifo_full_s, sel_ready_s;
  logic            fire_s, pop_s, load_s, drop_s, fetch_ready_s, push_s;

  // Head decode, handshake qualification and next-count/next-stage computation
  always_comb begin
    head_instr_s  = instr_mem_r[rd_ptr_r];
    head_pc_s     = pc_mem_r[rd_ptr_r];
    head_dec_s    = decode(head_instr_s[6:0], head_instr_s[31:25]);
    fifo_empty_s  = (count_r == CW'(0));
    fifo_full_s   = (count_r == CW'(QDEPTH));
    sel_ready_s   = 1'b0;
    case (stage_target_r)
      TGT_INT: sel_ready_s = rs_int_ready_i;
      TGT_MEM: sel_ready_s = rs_mem_ready_i;
      TGT_MUL: sel_ready_s = rs_mul_ready_i;
      default: sel_ready_s = 1'b0;
    endcase
    fire_s        = stage_valid_r & sel_ready_s;
    // An illegal head still needs a free output slot before it is dropped
    pop_s         = ~fifo_empty_s & (~stage_valid_r | fire_s) & ~flush_i;
    load_s        = pop_s & head_dec_s[5];
    drop_s        = pop_s & ~head_dec_s[5];
    fetch_ready_s = rst_n & ~fifo_full_s & (state_r != ST_FLUSH) & ~flush_i;
    push_s        = fetch_valid_i & fetch_ready_s;

    count_next_s = count_r;
    if (flush_i) begin
      count_next_s = CW'(0);
    end else begin
      case ({push_s, pop_s})
        2'b10:   count_next_s = count_r + CW'(1);
        2'b01:   count_next_s = count_r - CW'(1);
        default: count_next_s = count_r;
      endcase
    end

    stage_valid_next_s = stage_valid_r;
    if (flush_i) begin
      stage_valid_next_s = 1'b0;
    end else if (load_s) begin
      stage_valid_next_s = 1'b1;
    end else if (fire_s) begin
      stage_valid_next_s = 1'b0;
    end else begin
      stage_valid_next_s = stage_valid_r;
    end
  end

  // FIFO storage; only legal (non-flush) pushes write
  always_ff @(posedge clk) begin
    if (push_s) begin
      instr_mem_r[wr_ptr_r] <= fetch_instr_i;
      pc_mem_r[wr_ptr_r]    <= fetch_pc_i;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= CW'(0);
    end else if (flush_i) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= CW'(0);
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      count_r <= count_next_s;
    end
  end

  // Output stage: holds its payload until fired or replaced
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_valid_r  <= 1'b0;
      stage_target_r <= 2'b00;
      stage_instr_r  <= {XLEN{1'b0}};
      stage_pc_r     <= {XLEN{1'b0}};
      stage_imm_r    <= {XLEN{1'b0}};
    end else begin
      stage_valid_r <= stage_valid_next_s;
      if (load_s) begin
        stage_target_r <= head_dec_s[4:3];
        stage_instr_r  <= head_instr_s;
        stage_pc_r     <= head_pc_s;
        stage_imm_r    <= imm_gen(head_instr_s[31:7], head_dec_s[2:0]);
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic; flush overrides every state
  always_comb begin
    state_next_s = state_r;
    if (flush_i) begin
      state_next_s = ST_FLUSH;
    end else begin
      case (state_r)
        ST_IDLE:  state_next_s = fifo_empty_s ? ST_IDLE : ST_RUN;
        ST_RUN: begin
          if (stage_valid_r && !sel_ready_s) begin
            state_next_s = ST_STALL;
          end else if ((count_next_s == CW'(0)) && !stage_valid_next_s) begin
            state_next_s = ST_IDLE;
          end else begin
            state_next_s = ST_RUN;
          end
        end
        ST_STALL: state_next_s = fire_s ? ST_RUN : ST_STALL;
        ST_FLUSH: state_next_s = ST_IDLE;
        default:  state_next_s = ST_IDLE;
      endcase
    end
  end

  // FSM / datapath outputs
  always_comb begin
    fetch_ready_o = fetch_ready_s;
    illegal_o     = drop_s;
    disp_valid_o  = stage_valid_r;
    disp_target_o = stage_target_r;
    disp_instr_o  = stage_instr_r;
    disp_pc_o     = stage_pc_r;
    disp_imm_o    = stage_imm_r;
    state_o       = state_r;
  end

`ifdef DISPATCH_PERF_CNT_EN
  logic [31:0] perf_disp_cnt_r, perf_stall_cnt_r;

  // Performance counters survive flush; only rst_n clears them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_disp_cnt_r  <= 32'd0;
      perf_stall_cnt_r <= 32'd0;
    end else begin
      perf_disp_cnt_r  <= perf_disp_cnt_r + {31'd0, fire_s};
      perf_stall_cnt_r <= perf_stall_cnt_r + {31'd0, (state_r == ST_STALL)};
    end
  end

  assign perf_disp_cnt_o  = perf_disp_cnt_r;
  assign perf_stall_cnt_o = perf_stall_cnt_r;
`endif

endmodule
